// File: rtl/pkt_mem_writer.sv
// Write-side controller for the circular packet register file: stores framed
// byte streams, issues commit descriptors and drops bad or overflowing packets.
module pkt_mem_writer #(
  parameter int unsigned pBITS    = 8,
  parameter int unsigned pDEPTH   = 3072,
  parameter int unsigned pADDR    = 12,
  parameter int unsigned pMAX_LEN = 1518,
  parameter int unsigned pCNT     = 16
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [pBITS-1:0] idata,
  input  logic             ivalid,
  input  logic             isop,
  input  logic             ieop,
  input  logic             irel_valid,
  input  logic [pADDR-1:0] irel_len,
  output logic             owr_en,
  output logic [pADDR-1:0] ow_addr,
  output logic [pBITS-1:0] ow_data,
  output logic             odesc_valid,
  output logic [pADDR-1:0] odesc_addr,
  output logic [pADDR-1:0] odesc_len,
  output logic [pADDR:0]   ofree,
  output logic [pCNT-1:0]  odrop_cnt
);

  localparam int unsigned FW = pADDR + 2;
  localparam int unsigned LW = pADDR + 1;
  localparam logic [FW-1:0]    DEPTH_F = FW'(pDEPTH);
  localparam logic [pADDR-1:0] LAST    = pADDR'(pDEPTH - 1);
  localparam logic [LW-1:0]    MAXL    = LW'(pMAX_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_t;

  state_t           state_q, state_d;
  logic [pADDR-1:0] wptr_q, wptr_d;
  logic [pADDR-1:0] start_q, start_d;
  logic [LW-1:0]    len_q, len_d;
  logic [FW-1:0]    free_q, free_d;
  logic [pCNT-1:0]  drop_cnt_q, drop_cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [pADDR-1:0] w_addr_q, w_addr_d;
  logic [pBITS-1:0] w_data_q, w_data_d;
  logic             desc_valid_q, desc_valid_d;
  logic [pADDR-1:0] desc_addr_q, desc_addr_d;
  logic [pADDR-1:0] desc_len_q, desc_len_d;

  logic [FW-1:0]    avail, avail_c, restore, sum;
  logic [pADDR-1:0] base;
  logic [1:0]       drops;
  logic [pCNT:0]    cnt_ext;

  function automatic logic [pADDR-1:0] ptr_inc(input logic [pADDR-1:0] a);
    return (a == LAST) ? '0 : a + pADDR'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    start_d      = start_q;
    len_d        = len_q;
    wr_en_d      = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    desc_valid_d = 1'b0;
    desc_addr_d  = desc_addr_q;
    desc_len_d   = desc_len_q;
    restore      = '0;
    drops        = '0;
    base         = wptr_q;

    avail   = free_q + (irel_valid ? FW'(irel_len) : '0);
    avail_c = (avail > DEPTH_F) ? DEPTH_F : avail;

    if (ivalid) begin
      if (isop) begin
        // an open packet is abandoned; the new one reuses its start address
        if (state_q == ST_WRITE) begin
          restore = FW'(len_q);
          drops   = 2'd1;
          base    = start_q;
        end
        if ((avail_c + restore) == '0) begin
          drops   = drops + 2'd1;
          wptr_d  = base;
          state_d = ieop ? ST_IDLE : ST_DROP;
        end else begin
          wr_en_d  = 1'b1;
          w_addr_d = base;
          w_data_d = idata;
          wptr_d   = ptr_inc(base);
          start_d  = base;
          len_d    = LW'(1);
          state_d  = ieop ? ST_IDLE : ST_WRITE;
          if (ieop) begin
            desc_valid_d = 1'b1;
            desc_addr_d  = base;
            desc_len_d   = pADDR'(1);
          end
        end
      end else if (state_q == ST_WRITE) begin
        if (len_q >= MAXL || avail_c == '0) begin
          restore = FW'(len_q);
          drops   = 2'd1;
          wptr_d  = start_q;
          state_d = ieop ? ST_IDLE : ST_DROP;
        end else begin
          wr_en_d  = 1'b1;
          w_addr_d = wptr_q;
          w_data_d = idata;
          wptr_d   = ptr_inc(wptr_q);
          len_d    = len_q + LW'(1);
          if (ieop) begin
            desc_valid_d = 1'b1;
            desc_addr_d  = start_q;
            desc_len_d   = pADDR'(len_q + LW'(1));
            state_d      = ST_IDLE;
          end
        end
      end else if (state_q == ST_DROP && ieop) begin
        state_d = ST_IDLE;
      end
    end

    sum    = avail_c + restore - (wr_en_d ? FW'(1) : '0);
    free_d = (sum > DEPTH_F) ? DEPTH_F : sum;

    cnt_ext    = {1'b0, drop_cnt_q} + (pCNT + 1)'(drops);
    drop_cnt_d = cnt_ext[pCNT] ? '1 : cnt_ext[pCNT-1:0];
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      start_q      <= '0;
      len_q        <= '0;
      free_q       <= DEPTH_F;
      drop_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      desc_valid_q <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      start_q      <= start_d;
      len_q        <= len_d;
      free_q       <= free_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_en_q      <= wr_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      desc_valid_q <= desc_valid_d;
      desc_addr_q  <= desc_addr_d;
      desc_len_q   <= desc_len_d;
    end
  end

  assign owr_en      = wr_en_q;
  assign ow_addr     = w_addr_q;
  assign ow_data     = w_data_q;
  assign odesc_valid = desc_valid_q;
  assign odesc_addr  = desc_addr_q;
  assign odesc_len   = desc_len_q;
  assign ofree       = free_q[pADDR:0];
  assign odrop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_mem_writer.sv
// Scoreboard bench for pkt_mem_writer: expected writes/descriptors are queued
// as stimulus is driven and compared as the DUT emits them.
module tb_pkt_mem_writer;

  localparam int DEPTH = 3072;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic [7:0]  idata = '0;
  logic        ivalid = 1'b0, isop = 1'b0, ieop = 1'b0;
  logic        irel_valid = 1'b0;
  logic [11:0] irel_len = '0;
  logic        owr_en, odesc_valid;
  logic [11:0] ow_addr, odesc_addr, odesc_len;
  logic [7:0]  ow_data;
  logic [12:0] ofree;
  logic [15:0] odrop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_wa[$], exp_wd[$], exp_da[$], exp_dl[$];

  pkt_mem_writer #(.pBITS(8), .pDEPTH(DEPTH), .pADDR(12), .pMAX_LEN(1518), .pCNT(16)) dut (
    .iclk(iclk), .irst(irst), .idata(idata), .ivalid(ivalid), .isop(isop), .ieop(ieop),
    .irel_valid(irel_valid), .irel_len(irel_len), .owr_en(owr_en), .ow_addr(ow_addr),
    .ow_data(ow_data), .odesc_valid(odesc_valid), .odesc_addr(odesc_addr),
    .odesc_len(odesc_len), .ofree(ofree), .odrop_cnt(odrop_cnt)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge iclk) begin
    if (!irst) begin
      if (owr_en) begin
        chk("wr_expected", exp_wa.size() > 0, 1);
        if (exp_wa.size() > 0) begin
          chk("wr_addr", ow_addr, exp_wa.pop_front());
          chk("wr_data", ow_data, exp_wd.pop_front());
        end
      end
      if (odesc_valid) begin
        chk("desc_with_wr", owr_en, 1);
        chk("desc_expected", exp_da.size() > 0, 1);
        if (exp_da.size() > 0) begin
          chk("desc_addr", odesc_addr, exp_da.pop_front());
          chk("desc_len", odesc_len, exp_dl.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iclk); #1;
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    idata = d; ivalid = 1'b1; isop = s; ieop = e;
    @(posedge iclk); #1;
    ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; irel_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int seed, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 5) == 0) idle(1);
      beat(8'((seed + i) & 255), i == 0, eop_last && (i == n - 1));
    end
  endtask

  task automatic exp_pkt(input int start, input int nwr, input int seed, input int dlen);
    for (int i = 0; i < nwr; i++) begin
      exp_wa.push_back((start + i) % DEPTH);
      exp_wd.push_back((seed + i) & 255);
    end
    if (dlen > 0) begin
      exp_da.push_back(start);
      exp_dl.push_back(dlen);
    end
  endtask

  task automatic rel(input int n);
    irel_valid = 1'b1; irel_len = 12'(n);
    @(posedge iclk); #1;
    irel_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    irst = 1'b1;
    idle(2);
    chk({tag, "_wr_en"}, owr_en, 0);
    chk({tag, "_w_addr"}, ow_addr, 0);
    chk({tag, "_w_data"}, ow_data, 0);
    chk({tag, "_desc_valid"}, odesc_valid, 0);
    chk({tag, "_desc_addr"}, odesc_addr, 0);
    chk({tag, "_desc_len"}, odesc_len, 0);
    chk({tag, "_free"}, ofree, DEPTH);
    chk({tag, "_drop"}, odrop_cnt, 0);
    irst = 1'b0;
    idle(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge iclk); #1;
    do_reset("rst");

    // 64-byte packet from address 0
    exp_pkt(0, 64, 0, 64);
    send_pkt(64, 0, 1); idle(3);
    chk("free_64", ofree, 3008);
    rel(64);

    // advance write pointer to 3070, then wrap
    exp_pkt(64, 1500, 7, 1500);   send_pkt(1500, 7, 1);  idle(3); rel(1500);
    exp_pkt(1564, 1506, 9, 1506); send_pkt(1506, 9, 1);  idle(3); rel(1506);
    chk("free_prewrap", ofree, DEPTH);
    exp_pkt(3070, 5, 100, 5);     send_pkt(5, 100, 1);   idle(3); rel(5);

    // fill to 10 free words, then overflow
    exp_pkt(3, 1518, 11, 1518);   send_pkt(1518, 11, 1); idle(2);
    exp_pkt(1521, 1518, 13, 1518); send_pkt(1518, 13, 1); idle(2);
    exp_pkt(3039, 26, 15, 26);    send_pkt(26, 15, 1);   idle(3);
    chk("free_10", ofree, 10);
    exp_pkt(3065, 10, 50, 0);     send_pkt(20, 50, 1);   idle(3);
    chk("ovf_free", ofree, 10);
    chk("ovf_drop", odrop_cnt, 1);
    exp_pkt(3065, 8, 70, 8);      send_pkt(8, 70, 1);    idle(3);
    chk("free_2", ofree, 2);
    rel(3070);
    chk("free_full", ofree, DEPTH);
    rel(100);
    chk("rel_clamp", ofree, DEPTH);

    // isop breaking packet A
    exp_pkt(1, 30, 30, 0);        send_pkt(30, 30, 0);   idle(2);
    chk("free_a", ofree, DEPTH - 30);
    exp_pkt(1, 10, 90, 10);       send_pkt(10, 90, 1);   idle(3);
    chk("sop_drop", odrop_cnt, 2);
    chk("sop_free", ofree, DEPTH - 10);
    rel(10);

    // length limit
    exp_pkt(11, 1518, 20, 0);     send_pkt(1519, 20, 1); idle(3);
    chk("len_drop", odrop_cnt, 3);
    chk("len_free", ofree, DEPTH);
    beat(8'h55, 1'b0, 1'b0); beat(8'h56, 1'b0, 1'b1); idle(3);
    exp_pkt(11, 1518, 40, 1518);  send_pkt(1518, 40, 1); idle(3);
    chk("max_free", ofree, 1554);

    // release coinciding with a written beat
    exp_pkt(1529, 5, 200, 5);
    beat(8'd200, 1'b1, 1'b0);
    beat(8'd201, 1'b0, 1'b0);
    chk("pre_rel_free", ofree, 1552);
    irel_valid = 1'b1; irel_len = 12'd64;
    beat(8'd202, 1'b0, 1'b0);
    chk("rel_wr_free", ofree, 1615);
    beat(8'd203, 1'b0, 1'b0);
    beat(8'd204, 1'b0, 1'b1); idle(3);
    chk("post_rel_free", ofree, 1613);
    chk("drop_keep", odrop_cnt, 3);

    // reset with a packet open
    exp_pkt(1534, 3, 210, 0);
    beat(8'd210, 1'b1, 1'b0); beat(8'd211, 1'b0, 1'b0); beat(8'd212, 1'b0, 1'b0);
    idle(2);
    do_reset("midrst");

    // stray beats in IDLE, single-beat packet, then pointer from 0
    beat(8'h77, 1'b0, 1'b1); beat(8'h78, 1'b0, 1'b0); idle(2);
    exp_pkt(0, 1, 33, 1);         beat(8'd33, 1'b1, 1'b1); idle(2);
    exp_pkt(1, 4, 60, 4);         send_pkt(4, 60, 1);    idle(3);
    chk("end_free", ofree, DEPTH - 5);
    chk("end_drop", odrop_cnt, 0);

    chk("wr_q_empty", exp_wa.size(), 0);
    chk("desc_q_empty", exp_da.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
